// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: grants requests, byte-enabled read/write into a reset-cleared flop array,
// fixed-latency in-order responses, saturating activity counters. Optional grant stall injection
// is built in when TCDM_RESP_STALL_INJ_EN is defined.
module tcdm_bank_responder #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    BANK_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter int                    RESP_LATENCY = 1,
    parameter int                    CNT_WIDTH    = 32
`ifdef TCDM_RESP_STALL_INJ_EN
    ,
    parameter int                    STALL_RATE   = 4,
    parameter logic [15:0]           LFSR_SEED    = 16'hACE1
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    req_i,
    input  logic [ADDR_WIDTH-1:0]   add_i,
    input  logic                    wen_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    gnt_o,
    output logic                    r_valid_o,
    output logic [DATA_WIDTH-1:0]   r_rdata_o,
    output logic                    r_opc_o,
    output logic [CNT_WIDTH-1:0]    rd_cnt_o,
    output logic [CNT_WIDTH-1:0]    wr_cnt_o,
    output logic [CNT_WIDTH-1:0]    stall_cnt_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o
);

    localparam int          BE_WIDTH    = DATA_WIDTH / 8;
    localparam int          OFF_BITS    = $clog2(BE_WIDTH);
    localparam int          IDX_WIDTH   = $clog2(BANK_WORDS);
    localparam logic [31:0] ERR_PATTERN = 32'hBADC_AB1E;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_off;
    logic [IDX_WIDTH-1:0]  word_idx;
    logic                  in_range;
    logic                  xfer;
    logic                  wr_xfer;
    logic                  stall;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] err_word;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_opc;

    // ------------------------------------------------------------------
    // Grant generation
    // ------------------------------------------------------------------
`ifdef TCDM_RESP_STALL_INJ_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    // Fibonacci taps 16,14,13,11 shifting towards the MSB.
    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign stall = int'(lfsr_reg[3:0]) < STALL_RATE;
`else
    assign stall = 1'b0;
`endif

    assign gnt_o = req_i & ~stall;
    assign xfer  = req_i & gnt_o;

    // ------------------------------------------------------------------
    // Address decode; sub-word byte offset bits are ignored.
    // ------------------------------------------------------------------
    assign offset   = add_i - BASE_ADDR;
    assign word_off = offset >> OFF_BITS;
    assign word_idx = word_off[IDX_WIDTH-1:0];
    assign in_range = (add_i >= BASE_ADDR) && (word_off < ADDR_WIDTH'(BANK_WORDS));
    assign wr_xfer  = xfer & ~wen_i & in_range;

    // ------------------------------------------------------------------
    // Storage: one flop array per byte lane, cleared by reset.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
        logic [7:0] lane_mem_reg [BANK_WORDS];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int w = 0; w < BANK_WORDS; w++) begin
                    lane_mem_reg[w] <= '0;
                end
            end else if (wr_xfer && be_i[gi]) begin
                lane_mem_reg[word_idx] <= wdata_i[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = lane_mem_reg[word_idx];
    end

    // Error pattern repeated across (or truncated to) the data width.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_err
        assign err_word[gi] = ERR_PATTERN[gi % 32];
    end

    always_comb begin
        resp_opc  = ~in_range;
        resp_data = '0;
        if (!in_range) begin
            resp_data = err_word;
        end else if (wen_i) begin
            resp_data = rd_word;
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline. Data stages load only behind a valid entry, so the
    // last stage keeps the previous response while r_valid_o is low.
    // ------------------------------------------------------------------
    logic [RESP_LATENCY-1:0] vld_reg;
    logic [RESP_LATENCY-1:0] opc_reg;
    logic [DATA_WIDTH-1:0]   data_reg [RESP_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
            opc_reg <= '0;
            for (int s = 0; s < RESP_LATENCY; s++) begin
                data_reg[s] <= '0;
            end
        end else begin
            vld_reg[0] <= xfer;
            if (xfer) begin
                data_reg[0] <= resp_data;
                opc_reg[0]  <= resp_opc;
            end
            for (int s = 1; s < RESP_LATENCY; s++) begin
                vld_reg[s] <= vld_reg[s-1];
                if (vld_reg[s-1]) begin
                    data_reg[s] <= data_reg[s-1];
                    opc_reg[s]  <= opc_reg[s-1];
                end
            end
        end
    end

    assign r_valid_o = vld_reg[RESP_LATENCY-1];
    assign r_rdata_o = data_reg[RESP_LATENCY-1];
    assign r_opc_o   = opc_reg[RESP_LATENCY-1];

    // ------------------------------------------------------------------
    // Saturating counters: 0 = reads, 1 = writes, 2 = stalls, 3 = errors.
    // Reads and writes count every granted transfer, in range or not.
    // ------------------------------------------------------------------
    logic [3:0] cnt_event;

    assign cnt_event[0] = xfer & wen_i;
    assign cnt_event[1] = xfer & ~wen_i;
    assign cnt_event[2] = req_i & ~gnt_o;
    assign cnt_event[3] = xfer & ~in_range;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (clr_i) begin
                cnt_reg <= '0;
            end else if (cnt_event[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign rd_cnt_o    = g_cnt[0].cnt_reg;
    assign wr_cnt_o    = g_cnt[1].cnt_reg;
    assign stall_cnt_o = g_cnt[2].cnt_reg;
    assign err_cnt_o   = g_cnt[3].cnt_reg;

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
Responder (slave) end of the TCDM bus used by HWPE/traffic-generator master ports in the cluster accelerator region. Models one word-interleaved TCDM bank: grants requests, performs byte-enabled writes and reads into a local flop array, and returns responses after a fixed latency. Keeps saturating activity counters. Used standalone in accelerator-region benches and traffic tests in place of the real cluster interconnect and TCDM.

Parameters:
DATA_WIDTH, 32, data word width (multiple of 8)
ADDR_WIDTH, 32, byte address width
BANK_WORDS, 1024, number of words in bank (power of 2)
BASE_ADDR, 32'h1000_0000, byte address of word 0
RESP_LATENCY, 1, cycles from grant to r_valid (legal 1..4)
CNT_WIDTH, 32, width of activity counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr_i  in  1  synchronous clear of counters
req_i  in  1  request valid
add_i  in  ADDR_WIDTH  byte address
wen_i  in  1  1 = read, 0 = write (TCDM polarity)
wdata_i  in  DATA_WIDTH  write data
be_i  in  DATA_WIDTH/8  byte enables
gnt_o  out  1  request accepted this cycle
r_valid_o  out  1  response valid
r_rdata_o  out  DATA_WIDTH  read data
r_opc_o  out  1  1 = error response
rd_cnt_o  out  CNT_WIDTH  granted reads
wr_cnt_o  out  CNT_WIDTH  granted writes
stall_cnt_o  out  CNT_WIDTH  cycles with req_i=1, gnt_o=0
err_cnt_o  out  CNT_WIDTH  granted out-of-range requests

Behaviour:
- Clock clk; reset rst_n asynchronous active-low. Reset values: gnt_o/r_valid_o/r_opc_o 0, r_rdata_o 0, all counters 0, response pipeline empty, array all-zero.
- Grant: gnt_o combinational = req_i (feature off). Transfer = req_i & gnt_o in cycle N.
- Decode: offset = add_i - BASE_ADDR; word index = offset >> log2(DATA_WIDTH/8); low byte-offset bits ignored. In range iff add_i >= BASE_ADDR and index < BANK_WORDS.
- Write (wen_i=0, in range): bytes with be_i[k]=1 updated at end of cycle N; others unchanged. be_i=0 is a legal no-op write.
- Read (wen_i=1, in range): data sampled from array at cycle N (after any write in earlier cycles; a write and read cannot share a cycle — single port).
- Out-of-range: no array access; response r_opc_o=1, r_rdata_o=32'hBADC_AB1E replicated/truncated to DATA_WIDTH.
- Response: every transfer (read and write) yields exactly one r_valid_o pulse at cycle N+RESP_LATENCY with its r_rdata_o (0 for writes) and r_opc_o. Shift pipeline of depth RESP_LATENCY; back-to-back transfers give back-to-back responses, in order, no bubbles. r_rdata_o/r_opc_o hold last value when r_valid_o=0.
- Master must hold req_i/add_i/wen_i/wdata_i/be_i stable until granted; not checked.
- Counters: increment on respective event; saturate at all-ones; clr_i clears all four and wins over simultaneous increment.
- Reset mid-operation: pipeline flushed, in-flight responses dropped, no r_valid_o after rst_n deasserts until a new transfer.

Optional Feature:
TCDM_RESP_STALL_INJ_EN: adds parameters STALL_RATE (default 4, 0..15) and LFSR_SEED (16'hACE1, nonzero). 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle after reset. gnt_o = req_i & ~(lfsr[3:0] < STALL_RATE). STALL_RATE=0 gives no stalls. Without macro: gnt_o = req_i, stall_cnt_o constant 0, no LFSR logic.

Test Plan:
- Reset then write BASE_ADDR+8 data 32'hDEAD_BEEF be 4'hF, read it, RESP_LATENCY=1 -> read r_valid_o one cycle after grant, r_rdata_o=32'hDEAD_BEEF, r_opc_o=0; wr_cnt_o=1, rd_cnt_o=1.
- Write 32'h1122_3344 be 4'hF then 32'hAAAA_AAAA be 4'b0101 same address, read -> 32'h11AA_33AA.
- RESP_LATENCY=3, 8 back-to-back reads of addresses 0..7 preloaded with index -> 8 consecutive r_valid_o cycles starting 3 after first grant, data 0..7 in order.
- Read BASE_ADDR+4*BANK_WORDS and BASE_ADDR-4 -> two responses r_opc_o=1, r_rdata_o=32'hBADC_AB1E, err_cnt_o=2, array unchanged.
- Assert rst_n=0 with 2 responses in flight (RESP_LATENCY=4) -> no r_valid_o after release; counters 0; clr_i with simultaneous grant -> counters 0 next cycle.
- Feature on, STALL_RATE=15, req_i held 100 cycles -> gnt_o only when lfsr[3:0]=15; stall_cnt_o + grants = 100; STALL_RATE=0 -> stall_cnt_o=0.
